mem_responder_sim: RTL and testbench
====================================

Name: mem_responder_sim

Overview:
- Simulation-only responder for the Ibex-style host interface (req/gnt/rvalid, in-order responses). It connects directly to an instruction or data port of `ibex_top_tracing`, or to a bus host port, in place of the bus plus `ram_1p`.
- Backing store is a word array with byte-enable writes.
- An LFSR produces randomised grant stalls and per-request response latency, so the core's LSU and prefetch buffer are exercised under variable timing.
- Out-of-range addresses return `err`.

Parameters:
- DepthWords, 16384, memory size in 32-bit words; must be a power of 2.
- MaxOutstanding, 4, response-queue depth (2..8).
- MinLatency, 1, minimum gnt-to-rvalid cycles; must be >= 1.
- MaxLatency, 4, maximum gnt-to-rvalid cycles; must be >= MinLatency and <= 15.
- StallEn, 1'b1, enables random grant stalls.
- LfsrSeed, 16'hACE1, LFSR reset value; must be non-zero.
- BaseAddr, 32'h0, byte address of word 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one cycle per accepted request
- rdata_o  out  32  read data
- err_o  out  1  error response, qualified by rvalid_o

Behaviour:
- **Reset** (async assert, sync release):
  - `gnt_o`, `rvalid_o`, `err_o` = 0; `rdata_o` = 0.
  - Queue is emptied; LFSR = LfsrSeed.
  - Memory contents are not reset.
  - Reset mid-operation drops all pending responses; no `rvalid_o` occurs for requests granted before reset.
- **LFSR**:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle out of reset.
  - `stall = StallEn & (lfsr[1:0] == 2'b00)`.
  - `lat = MinLatency + (lfsr[7:4] % (MaxLatency-MinLatency+1))`.
- **Grant**: combinational, `gnt_o = req_i & ~full & ~stall & ~rst_i`. The host must hold req/addr/we/be/wdata stable until granted; that is the host's obligation and is not checked here.
- **Accept** (`req_i & gnt_o` at a rising edge):
  - Range: `in_range = ((addr_i - BaseAddr) >> 2) < DepthWords`.
  - Write, in range: bytes with `be_i[k]=1` are committed at that edge.
  - Read, in range: word is captured at that edge; `rdata` = array word.
  - Out of range: no write; `rdata = 0`, `err = 1`.
  - Write responses carry `rdata = 0`, `err = !in_range`.
  - One entry `{rdata, err, cnt=lat}` is pushed to the queue.
- **Countdown**: every entry's `cnt` decrements each cycle, saturating at 0.
- **Response**:
  - When the head entry has `cnt == 0`, `rvalid_o=1` with its `rdata`/`err` for exactly one cycle, and the head is popped.
  - At most one response per cycle; responses are strictly in acceptance order.
  - With an empty queue, a request accepted at edge N produces `rvalid_o` in cycle N+lat, or later if earlier entries are still pending.
  - Latency >= 1, so `rvalid_o` is never asserted in the grant cycle for the same request.
  - When `rvalid_o=0`, `rdata_o` and `err_o` are driven to 0.
- **Full/empty**:
  - `full = (count == MaxOutstanding)`.
  - Push and pop in the same cycle is legal when full; `gnt_o` still uses the pre-pop `full` (conservative).
  - Count never exceeds MaxOutstanding or underflows.
- **Read-after-write**: a read granted the cycle after a write to the same word returns the new data.
- **Wrap-around**: the queue read and write pointers wrap modulo MaxOutstanding.
- **Assertions**:
  - No `rvalid_o` while the queue is empty.
  - `count <= MaxOutstanding`.
  - Parameter checks at elaboration.

Decomposition:
- Package `mem_responder_pkg`:
  - `resp_entry_t` struct `{logic [31:0] rdata; logic err; logic [3:0] cnt;}`.
  - LFSR polynomial constant `LfsrPoly = 16'hB400`.
- Sub-module `mem_responder_resp_queue`: parameterised circular FIFO of `resp_entry_t` with per-entry countdown and head-ready output.
- LFSR and memory array stay in the top.

Test Plan:
- StallEn=0, MinLatency=MaxLatency=1: write 0xDEADBEEF to 0x100 (be=4'hF), then read 0x100 → `gnt_o` in the request cycle each time; `rvalid_o` one cycle after each grant; read `rdata_o=0xDEADBEEF`, `err_o=0`.
- Byte enables: write 0x11223344 to 0x200 with be=4'hF, then 0xAABBCCDD with be=4'b0101, then read → `rdata_o=0x11BB33DD`.
- Out of range, DepthWords=16384: read 0x10000 and write 0x10004 → `err_o=1`, `rdata_o=0`; a subsequent read of 0x4 returns its prior contents unchanged.
- Back-pressure: StallEn=0, MaxOutstanding=4, Min=Max=15, back-to-back reads → exactly 4 grants, then `gnt_o=0` until the first `rvalid_o`; 4 in-order responses with correct data.
- Random stress: StallEn=1, Min=1, Max=4, 10k random read/write ops against a scoreboard model → data matches, responses in order, one `rvalid_o` per grant, `count` never exceeds 4.
- Reset mid-operation: assert `rst_i` with 3 entries pending → `rvalid_o=0` immediately and for the rest of the reset; no stale responses after release; memory data written before reset reads back unchanged.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the randomised-latency memory responder.
// Response-queue entry layout and the LFSR stepping function live here.
package mem_responder_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  cnt;
  } resp_entry_t;

  // Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LfsrPoly = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Ibex-style host bus: req/gnt request phase, in-order rvalid response phase.
interface mem_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_responder_resp_queue.sv
// Circular FIFO of pending responses; every entry counts down in parallel and
// the head is presented once its count has reached zero.
module mem_responder_resp_queue
  import mem_responder_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned CW    = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  resp_entry_t   push_entry_i,
  input  logic          pop_i,
  output resp_entry_t   head_o,
  output logic          head_ready_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

  resp_entry_t   ent_q [Depth];
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < Depth; i++)
        if (ent_q[i].cnt != '0) ent_q[i].cnt <= ent_q[i].cnt - 4'd1;
      if (push_i) begin
        ent_q[wptr_q] <= push_entry_i;
        wptr_q        <= wrap_inc(wptr_q);
      end
      if (pop_i) rptr_q <= wrap_inc(rptr_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o       = ent_q[rptr_q];
  assign empty_o      = (cnt_q == '0);
  assign full_o       = (cnt_q == CW'(Depth));
  assign head_ready_o = !empty_o && (head_o.cnt == '0);
  assign count_o      = cnt_q;

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CW'(Depth));
  a_pop_nonempty: assert property (@(posedge clk_i) disable iff (rst_i) pop_i |-> !empty_o);

endmodule

// File: rtl/mem_responder_sim.sv
// Simulation memory responder: word array with byte-enable writes, LFSR-driven
// grant stalls and per-request response latency, err for out-of-range addresses.
module mem_responder_sim
  import mem_responder_pkg::*;
#(
  parameter int unsigned DepthWords     = 16384,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned MinLatency     = 1,
  parameter int unsigned MaxLatency     = 4,
  parameter bit          StallEn        = 1'b1,
  parameter logic [15:0] LfsrSeed       = 16'hACE1,
  parameter logic [31:0] BaseAddr       = 32'h0
) (
  input logic             clk_i,
  input logic             rst_i,
  mem_responder_if.slave  bus
);

  localparam int unsigned AW      = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam int unsigned CW      = $clog2(MaxOutstanding + 1);
  localparam logic [3:0]  LatSpan = 4'(MaxLatency - MinLatency + 1);

  if (DepthWords == 0 || (DepthWords & (DepthWords - 1)) != 0) begin : g_bad_depth
    $error("DepthWords must be a non-zero power of 2");
  end
  if (MaxOutstanding < 2 || MaxOutstanding > 8) begin : g_bad_outst
    $error("MaxOutstanding must be in 2..8");
  end
  if (MinLatency < 1 || MaxLatency < MinLatency || MaxLatency > 15) begin : g_bad_lat
    $error("latency bounds must satisfy 1 <= MinLatency <= MaxLatency <= 15");
  end
  if (LfsrSeed == 16'h0) begin : g_bad_seed
    $error("LfsrSeed must be non-zero");
  end

  logic [15:0]   lfsr_q, lfsr_d;
  logic          stall, accept, in_range;
  logic [31:0]   word_off;
  logic [AW-1:0] idx;
  logic [3:0]    lat;
  resp_entry_t   push_entry, head;
  logic          head_ready, full, empty;
  logic [CW-1:0] count;
  logic [31:0]   mem [DepthWords];

  assign lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LfsrSeed;
    else       lfsr_q <= lfsr_d;
  end

  assign stall    = StallEn & (lfsr_q[1:0] == 2'b00);
  assign lat      = 4'(MinLatency) + (lfsr_q[7:4] % LatSpan);
  assign bus.gnt  = bus.req & ~full & ~stall & ~rst_i;
  assign accept   = bus.req & bus.gnt;
  assign word_off = (bus.addr - BaseAddr) >> 2;
  assign in_range = (word_off < DepthWords);
  assign idx      = word_off[AW-1:0];

  // Contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && bus.we && in_range)
      for (int k = 0; k < 4; k++)
        if (bus.be[k]) mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
  end

  // The accept edge is itself the first latency cycle, hence lat-1.
  always_comb begin
    push_entry     = '0;
    push_entry.err = ~in_range;
    push_entry.cnt = lat - 4'd1;
    if (!bus.we && in_range) push_entry.rdata = mem[idx];
  end

  mem_responder_resp_queue #(.Depth(MaxOutstanding)) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (head_ready),
    .head_o       (head),
    .head_ready_o (head_ready),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count)
  );

  assign bus.rvalid = head_ready;
  assign bus.rdata  = head_ready ? head.rdata : '0;
  assign bus.err    = head_ready & head.err;

  a_rvalid_nonempty: assert property (@(posedge clk_i) disable iff (rst_i) bus.rvalid |-> !empty);
  a_count_max: assert property (@(posedge clk_i) disable iff (rst_i) count <= CW'(MaxOutstanding));

endmodule

// File: tb/tb_mem_responder_sim.sv
// Bench for mem_responder_sim: three configurations (fixed 1-cycle, fixed
// 15-cycle, randomised) driven by directed steps plus a random scoreboard run.
module tb_mem_responder_sim;

  localparam logic [31:0] RBASE = 32'h1000;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          g;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if f_if ();
  mem_responder_if s_if ();
  mem_responder_if r_if ();

  mem_responder_sim #(.DepthWords(16384), .MaxOutstanding(4), .MinLatency(1), .MaxLatency(1),
    .StallEn(1'b0), .LfsrSeed(16'hACE1), .BaseAddr(32'h0))
    u_fast (.clk_i(clk), .rst_i(rst), .bus(f_if));
  mem_responder_sim #(.DepthWords(1024), .MaxOutstanding(4), .MinLatency(15), .MaxLatency(15),
    .StallEn(1'b0), .LfsrSeed(16'hACE1), .BaseAddr(32'h0))
    u_slow (.clk_i(clk), .rst_i(rst), .bus(s_if));
  mem_responder_sim #(.DepthWords(64), .MaxOutstanding(4), .MinLatency(1), .MaxLatency(4),
    .StallEn(1'b1), .LfsrSeed(16'hACE1), .BaseAddr(RBASE))
    u_rand (.clk_i(clk), .rst_i(rst), .bus(r_if));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single transaction on the 1-cycle responder: grant in the request cycle,
  // response in the following cycle.
  task automatic f_op(input logic we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                      input string tag);
    f_if.req = 1'b1; f_if.we = we; f_if.addr = a; f_if.be = be; f_if.wdata = wd;
    @(negedge clk);
    chk({tag, ".gnt"}, f_if.gnt, 1);
    chk({tag, ".rv_early"}, f_if.rvalid, 0);
    @(posedge clk); #1;
    f_if.req = 1'b0; f_if.we = 1'b0;
    @(negedge clk);
    chk({tag, ".rvalid"}, f_if.rvalid, 1);
    chk({tag, ".rdata"}, f_if.rdata, erd);
    chk({tag, ".err"}, f_if.err, eerr);
    @(posedge clk); #1;
  endtask

  task automatic s_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input string tag);
    int n;
    s_if.req = 1'b1; s_if.we = we; s_if.addr = a; s_if.be = 4'hF; s_if.wdata = wd;
    n = 0;
    @(negedge clk);
    while (!s_if.gnt && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".gnt"}, s_if.gnt, 1);
    @(posedge clk); #1;
    s_if.req = 1'b0; s_if.we = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_if.rvalid && n < 40) begin @(negedge clk); n++; end
    chk({tag, ".rvalid"}, s_if.rvalid, 1);
    chk({tag, ".rdata"}, s_if.rdata, erd);
    chk({tag, ".err"}, s_if.err, 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard for the randomised responder.
  exp_t        rq[$];
  logic [31:0] rmem [64];
  bit          mon_en = 1'b0;
  int          r_out = 0, r_grants = 0, r_resps = 0, prev_r = -1;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      exp_t        e;
      logic [31:0] off;
      int          hi;
      chk("r.count_bound", 32'(r_out <= 4), 1);
      if (r_out == 4) chk("r.full_gnt", r_if.gnt, 0);
      if (r_if.rvalid) begin
        chk("r.nonempty", 32'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          e = rq.pop_front();
          chk("r.rdata", r_if.rdata, e.rd);
          chk("r.err", r_if.err, e.e);
          chk("r.lat_min", 32'(cyc >= e.g + 1), 1);
          hi = (e.g + 4 > prev_r + 1) ? e.g + 4 : prev_r + 1;
          chk("r.lat_max", 32'(cyc <= hi), 1);
          prev_r = cyc;
          r_resps++;
          r_out--;
        end
      end else begin
        chk("r.idle_zero", r_if.rdata | 32'(r_if.err), 0);
      end
      if (r_if.req && r_if.gnt) begin
        off  = r_if.addr - RBASE;
        e.e  = !((off >> 2) < 64);
        e.rd = '0;
        e.g  = cyc;
        if (!e.e) begin
          if (r_if.we) begin
            for (int k = 0; k < 4; k++)
              if (r_if.be[k]) rmem[off[7:2]][8*k +: 8] = r_if.wdata[8*k +: 8];
          end else begin
            e.rd = rmem[off[7:2]];
          end
        end
        rq.push_back(e);
        r_out++;
        r_grants++;
      end
    end
  end

  initial begin
    int          n, stale, nxt;
    int          gcyc[$], rcyc[$];
    logic [31:0] rdq[$];
    logic [31:0] a;
    logic        w;
    logic [3:0]  be;
    int          exp_g[5];
    int          exp_r[5];
    exp_g = '{0, 1, 2, 3, 16};
    exp_r = '{15, 16, 17, 18, 31};

    f_if.req = 1'b1; f_if.we = 1'b0; f_if.addr = '0; f_if.be = '0; f_if.wdata = '0;
    s_if.req = 1'b0; s_if.we = 1'b0; s_if.addr = '0; s_if.be = '0; s_if.wdata = '0;
    r_if.req = 1'b0; r_if.we = 1'b0; r_if.addr = '0; r_if.be = '0; r_if.wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.gnt_masked", f_if.gnt, 0);
    chk("rst.rvalid", f_if.rvalid, 0);
    chk("rst.rdata", f_if.rdata, 0);
    chk("rst.err", f_if.err, 0);
    f_if.req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle.gnt", f_if.gnt, 0);
    chk("idle.rvalid", f_if.rvalid, 0);
    @(posedge clk); #1;

    // Basic write/read, byte enables, range edges
    f_op(1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0, "wr100");
    f_op(0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, "rd100");
    f_op(1, 32'h200, 4'hF, 32'h11223344, 32'h0, 0, "wr200");
    f_op(1, 32'h200, 4'b0101, 32'hAABBCCDD, 32'h0, 0, "wr200be");
    f_op(0, 32'h202, 4'hF, 32'h0, 32'h11BB33DD, 0, "rd200be");
    f_op(1, 32'h4, 4'hF, 32'h12345678, 32'h0, 0, "wr4");
    f_op(1, 32'hFFFC, 4'hF, 32'hC0FFEE01, 32'h0, 0, "wrlast");
    f_op(0, 32'hFFFC, 4'hF, 32'h0, 32'hC0FFEE01, 0, "rdlast");
    f_op(0, 32'h10000, 4'hF, 32'h0, 32'h0, 1, "rdoor");
    f_op(1, 32'h10004, 4'hF, 32'hFFFFFFFF, 32'h0, 1, "wroor");
    f_op(0, 32'h4, 4'hF, 32'h0, 32'h12345678, 0, "rd4");

    // Read granted the cycle after a write to the same word
    f_if.req = 1'b1; f_if.we = 1'b1; f_if.addr = 32'h300; f_if.be = 4'hF; f_if.wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("raw.wgnt", f_if.gnt, 1);
    @(posedge clk); #1;
    f_if.we = 1'b0;
    @(negedge clk);
    chk("raw.rgnt", f_if.gnt, 1);
    chk("raw.wresp", f_if.rvalid, 1);
    chk("raw.wresp_data", f_if.rdata, 0);
    @(posedge clk); #1;
    f_if.req = 1'b0;
    @(negedge clk);
    chk("raw.rresp", f_if.rvalid, 1);
    chk("raw.rdata", f_if.rdata, 32'hCAFEF00D);
    @(posedge clk); #1;

    // Back-pressure with latency 15
    for (int i = 0; i < 5; i++)
      s_op(1, 32'h40 + 32'(4 * i), 32'hB0000000 + 32'(i * 32'h111), 32'h0, "sfill");
    nxt = 0;
    s_if.req = 1'b1; s_if.we = 1'b0; s_if.addr = 32'h40;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_if.rvalid) begin rcyc.push_back(c); rdq.push_back(s_if.rdata); end
      if (s_if.req && s_if.gnt) begin gcyc.push_back(c); nxt++; end
      @(posedge clk); #1;
      if (nxt < 5) s_if.addr = 32'h40 + 32'(4 * nxt);
      else         s_if.req = 1'b0;
    end
    chk("bp.ngrants", gcyc.size(), 5);
    chk("bp.nresps", rcyc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("bp.gnt_cycle", (gcyc.size() > i) ? gcyc[i] : -1, exp_g[i]);
      chk("bp.resp_cycle", (rcyc.size() > i) ? rcyc[i] : -1, exp_r[i]);
      chk("bp.rdata", (rdq.size() > i) ? rdq[i] : 32'hX, 32'hB0000000 + 32'(i * 32'h111));
    end

    // Reset with three responses pending
    s_op(1, 32'h80, 32'h5A5A1234, 32'h0, "swr80");
    s_if.req = 1'b1; s_if.we = 1'b0; s_if.addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pend.gnt", s_if.gnt, 1);
      @(posedge clk); #1;
    end
    s_if.req = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("pend.due", s_if.rvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.rvalid", s_if.rvalid, 0);
    chk("rstmid.rdata", s_if.rdata, 0);
    s_if.req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid.hold_rvalid", s_if.rvalid, 0);
      chk("rstmid.hold_gnt", s_if.gnt, 0);
    end
    s_if.req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_if.rvalid || f_if.rvalid || r_if.rvalid) stale++;
    end
    chk("rstmid.stale", stale, 0);
    @(posedge clk); #1;
    s_op(0, 32'h80, 32'h0, 32'h5A5A1234, "srd80");
    f_op(0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, "frd100_post");

    // Random stress with stalls and 1..4 latency
    mon_en = 1'b1;
    for (int i = 0; i < 10064; i++) begin
      if (i < 64) begin
        a = RBASE + 32'(4 * i); w = 1'b1; be = 4'hF;
      end else begin
        a  = 32'h0F00 + 32'(4 * $urandom_range(0, 191)) + 32'($urandom_range(0, 3));
        w  = 1'($urandom_range(0, 1));
        be = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) begin
          r_if.req = 1'b0;
          @(posedge clk); #1;
        end
      end
      r_if.req = 1'b1; r_if.we = w; r_if.addr = a; r_if.be = be; r_if.wdata = $urandom;
      n = 0;
      @(negedge clk);
      while (!r_if.gnt && n < 64) begin @(negedge clk); n++; end
      if (!r_if.gnt) begin
        chk("r.gnt_timeout", r_if.gnt, 1);
        break;
      end
      @(posedge clk); #1;
    end
    r_if.req = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("r.drain", rq.size(), 0);
    chk("r.balance", r_grants, r_resps);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
